// File: rtl/spi_bmp_pkg.sv
// spi_bmp_pkg: shared state encoding and BMP280 constants for the SPI master.
// SPI_CS_GUARD_EN enables the CS_SETUP/CS_HOLD guard states in spi_bmp_master.
package spi_bmp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      ADDR,
      DATA,
      CS_HOLD,
      STOP
   } state_t;

   localparam logic BMP_RD_BIT = 1'b1;
   localparam logic BMP_WR_BIT = 1'b0;

   localparam logic [6:0] BMP_ID_ADDR         = 7'h50;
   localparam logic [6:0] BMP_CTRL_MEAS_ADDR  = 7'h74;
   localparam logic [6:0] BMP_DATA_START_ADDR = 7'h77;

endpackage

// File: rtl/spi_edge_det.sv
// spi_edge_det: registers the divided SPI clock and produces one-clk
// rise/fall pulses for the transaction engine.
module spi_edge_det (
   input  logic clk,
   input  logic reset_n,
   input  logic s_clk,
   output logic rise,
   output logic fall
);

   logic s_clk_q;

   // one-cycle delayed copy of s_clk for edge comparison
   always_ff @(posedge clk) begin
      if (!reset_n) s_clk_q <= 1'b0;
      else          s_clk_q <= s_clk;
   end

   assign rise = s_clk & ~s_clk_q;
   assign fall = ~s_clk & s_clk_q;

endmodule

// File: rtl/spi_bmp_master.sv
// spi_bmp_master: SPI mode-0 engine for the BMP280 (one write or burst read).
// Define SPI_CS_GUARD_EN to add CS_GUARD-cycle cs_n setup/hold guard states.
module spi_bmp_master
   import spi_bmp_pkg::*;
#(
   parameter int MAX_BYTES = 6,
   parameter int NB_W      = 3,
   parameter int CS_GUARD  = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            rw,
   input  logic [6:0]      addr,
   input  logic [7:0]      wr_data,
   input  logic [NB_W-1:0] n_bytes,
   output logic            busy,
   output logic            done,
   output logic [7:0]      rd_data,
   output logic            rd_valid,
   output logic            enable_div,
   input  logic            s_clk,
   output logic            sclk,
   output logic            cs_n,
   output logic            mosi,
   input  logic            miso
);

   state_t            state;
   logic              rd_mode;
   logic [15:0]       tx_sr;
   logic [6:0]        rx_sr;
   logic [2:0]        bit_cnt;
   logic [NB_W-1:0]   bytes_left;
   logic [NB_W-1:0]   start_cnt;
   logic              rise;
   logic              fall;

`ifdef SPI_CS_GUARD_EN
   localparam int GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
   logic [GW-1:0]     guard_cnt;
`endif

   assign sclk = s_clk;

   spi_edge_det u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .s_clk   (s_clk),
      .rise    (rise),
      .fall    (fall)
   );

   // byte count to latch: writes carry one byte, bad read lengths clamp
   always_comb begin
      start_cnt = n_bytes;
      if (rw != BMP_RD_BIT)
         start_cnt = NB_W'(1);
      else if (n_bytes == '0 || n_bytes > NB_W'(MAX_BYTES))
         start_cnt = NB_W'(MAX_BYTES);
   end

   // transaction FSM with command/data shifters and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= 8'h00;
         enable_div <= 1'b0;
         cs_n       <= 1'b1;
         mosi       <= 1'b0;
         rd_mode    <= 1'b0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         bytes_left <= '0;
`ifdef SPI_CS_GUARD_EN
         guard_cnt  <= '0;
`endif
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rd_mode    <= (rw == BMP_RD_BIT);
                  // address bits after the r/w bit, then the data byte
                  tx_sr      <= {addr,
                                 (rw == BMP_RD_BIT) ? 8'h00 : wr_data,
                                 1'b0};
                  bytes_left <= start_cnt;
                  bit_cnt    <= '0;
                  cs_n       <= 1'b0;
                  mosi       <= rw;
                  busy       <= 1'b1;
`ifdef SPI_CS_GUARD_EN
                  guard_cnt  <= GW'(CS_GUARD - 1);
                  state      <= CS_SETUP;
`else
                  enable_div <= 1'b1;
                  state      <= ADDR;
`endif
               end
            end
`ifdef SPI_CS_GUARD_EN
            CS_SETUP: begin
               if (guard_cnt == '0) begin
                  enable_div <= 1'b1;
                  state      <= ADDR;
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
`endif
            ADDR: begin
               if (rise) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= DATA;
               end
               if (fall) begin
                  mosi  <= tx_sr[15];
                  tx_sr <= {tx_sr[14:0], 1'b0};
               end
            end
            DATA: begin
               if (rise) begin
                  rx_sr   <= {rx_sr[5:0], miso};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     bytes_left <= bytes_left - 1'b1;
                     if (rd_mode) begin
                        rd_data  <= {rx_sr, miso};
                        rd_valid <= 1'b1;
                     end
                  end
               end
               if (fall) begin
                  if (bytes_left == '0) begin
                     enable_div <= 1'b0;
                     mosi       <= 1'b0;
`ifdef SPI_CS_GUARD_EN
                     guard_cnt  <= GW'(CS_GUARD - 1);
                     state      <= CS_HOLD;
`else
                     cs_n       <= 1'b1;
                     state      <= STOP;
`endif
                  end else begin
                     mosi  <= tx_sr[15];
                     tx_sr <= {tx_sr[14:0], 1'b0};
                  end
               end
            end
`ifdef SPI_CS_GUARD_EN
            CS_HOLD: begin
               if (guard_cnt == '0) begin
                  cs_n  <= 1'b1;
                  state <= STOP;
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
`endif
            STOP: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_bmp_master.sv
// tb_spi_bmp_master: table-driven and random transactions against a
// divider model, an SPI slave model and a transaction-level reference.
module tb_spi_bmp_master;

   localparam int MAXB  = 6;
   localparam int HALF  = 2;
   localparam int GUARD = 4;
`ifdef SPI_CS_GUARD_EN
   localparam int EXP_GAP = GUARD;
`else
   localparam int EXP_GAP = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = '0;
   logic [7:0] wr_data = '0;
   logic [2:0] n_bytes = '0;
   logic       miso = 1'b0;
   logic       busy, done, rd_valid, enable_div;
   logic       sclk, cs_n, mosi, s_clk;
   logic [7:0] rd_data;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   spi_bmp_master #(
      .MAX_BYTES (MAXB),
      .NB_W      (3),
      .CS_GUARD  (GUARD)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .rw         (rw),
      .addr       (addr),
      .wr_data    (wr_data),
      .n_bytes    (n_bytes),
      .busy       (busy),
      .done       (done),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .enable_div (enable_div),
      .s_clk      (s_clk),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .miso       (miso)
   );

   // clock divider model: ratio 2*HALF, output forced low when disabled
   logic div_q = 1'b0;
   int   dcnt = 0;
   always @(posedge clk) begin
      if (!enable_div) begin
         div_q <= 1'b0;
         dcnt  <= 0;
      end else if (dcnt == HALF - 1) begin
         div_q <= ~div_q;
         dcnt  <= 0;
      end else begin
         dcnt <= dcnt + 1;
      end
   end
   assign s_clk = div_q & enable_div;

   // SPI slave model: samples mosi on sclk rise, returns slave_resp
   logic [47:0] slave_resp = '0;
   int          srise = 0;
   bit          mosi_bits[$];

   function automatic logic slave_bit(int k);
      int idx;
      if (k < 8) return 1'b0;
      idx = k - 8;
      if (idx < 48) return slave_resp[47 - idx];
      return 1'b0;
   endfunction

   always @(posedge sclk or negedge cs_n) begin
      if (sclk) begin
         if (!cs_n) begin
            mosi_bits.push_back(mosi);
            srise++;
         end
      end else begin
         srise = 0;
         mosi_bits.delete();
      end
   end

   always @(negedge sclk or negedge cs_n) miso = slave_bit(srise);

   // transaction monitor, sampled on the falling clk edge
   logic [7:0] got[$];
   int cyc = 0, done_cnt = 0, cs_rise = 0, sclk_bad = 0;
   int last_v = 0, done_cyc = 0, csf_cyc = 0, enr_cyc = 0;
   logic prev_cs = 1'b1, prev_en = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (prev_cs && !cs_n) begin
         got.delete();
         done_cnt = 0;
         cs_rise  = 0;
         csf_cyc  = cyc;
      end
      if (!prev_cs && cs_n) cs_rise++;
      if (!prev_en && enable_div) enr_cyc = cyc;
      if (rd_valid) begin
         got.push_back(rd_data);
         last_v = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cs_n && sclk) sclk_bad++;
      prev_cs = cs_n;
      prev_en = enable_div;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int model_n(input logic r, input logic [2:0] n);
      if (!r) return 1;
      if (n == 0 || n > MAXB) return MAXB;
      return int'(n);
   endfunction

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: busy still %0b", busy);
      end
   endtask

   task automatic launch(input logic r, input logic [6:0] a,
                         input logic [7:0] wd, input logic [2:0] n,
                         input logic [47:0] resp);
      wait_idle();
      @(negedge clk);
      slave_resp = resp;
      start   = 1'b1;
      rw      = r;
      addr    = a;
      wr_data = wd;
      n_bytes = n;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input string nm);
      int k = 0;
      while (done_cnt == 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt == 0) begin
         total++;
         bad++;
         $display("FAIL %s.timeout: done seen %0d want 1", nm, done_cnt);
      end
   endtask

   task automatic verify(input string nm, input logic r,
                         input logic [6:0] a, input logic [7:0] wd,
                         input logic [2:0] n, input logic [47:0] resp,
                         input logic [7:0] exp_cmd, input int exp_rises,
                         input int exp_nval);
      int nb, errs;
      logic [7:0] first;
      bit exp_bits[$];
      repeat (4) @(negedge clk);
      nb = model_n(r, n);
      for (int i = 7; i >= 0; i--)
         exp_bits.push_back(i == 7 ? r : a[i]);
      for (int b = 0; b < nb; b++)
         for (int i = 7; i >= 0; i--)
            exp_bits.push_back(r ? 1'b0 : wd[i]);
      errs = 0;
      if (mosi_bits.size() != exp_bits.size()) errs++;
      else foreach (exp_bits[i])
         if (mosi_bits[i] != exp_bits[i]) errs++;
      first = '0;
      for (int i = 0; i < 8 && i < mosi_bits.size(); i++)
         first = {first[6:0], mosi_bits[i]};
      chk({nm, ".cmd"}, first, exp_cmd);
      chk({nm, ".mosi_bits"}, errs, 0);
      chk({nm, ".rises"}, srise, exp_rises);
      chk({nm, ".n_valid"}, got.size(), exp_nval);
      for (int i = 0; i < got.size() && i < MAXB; i++)
         chk($sformatf("%s.byte%0d", nm, i), got[i], resp[47 - 8*i -: 8]);
      chk({nm, ".done_cnt"}, done_cnt, 1);
      chk({nm, ".cs_rise"}, cs_rise, 1);
      chk({nm, ".busy_end"}, busy, 1'b0);
      chk({nm, ".cs_n_end"}, cs_n, 1'b1);
      chk({nm, ".mosi_idle"}, mosi, 1'b0);
      chk({nm, ".cs_to_en"}, enr_cyc - csf_cyc, EXP_GAP);
      if (r) chk({nm, ".valid_before_done"}, last_v < done_cyc, 1);
   endtask

   typedef struct {
      logic        r;
      logic [6:0]  a;
      logic [7:0]  wd;
      logic [2:0]  n;
      logic [47:0] resp;
      logic [7:0]  exp_cmd;
      int          exp_rises;
      int          exp_nval;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [63:0] rnd;
      logic        rr;
      logic [6:0]  ra;
      logic [7:0]  rwd;
      logic [2:0]  rn;
      int          k;

      tbl[0] = '{1'b1, 7'h50, 8'h00, 3'd1, 48'h58_00_00_00_00_00,
                 8'hD0, 16, 1};
      tbl[1] = '{1'b0, 7'h74, 8'h27, 3'd0, 48'h00_00_00_00_00_00,
                 8'h74, 16, 0};
      tbl[2] = '{1'b1, 7'h77, 8'h00, 3'd6, 48'h80_00_00_80_00_00,
                 8'hF7, 56, 6};
      tbl[3] = '{1'b1, 7'h77, 8'h00, 3'd0, 48'hA1_B2_C3_D4_E5_F6,
                 8'hF7, 56, 6};
      tbl[4] = '{1'b1, 7'h50, 8'hFF, 3'd7, 48'h01_23_45_67_89_AB,
                 8'hD0, 56, 6};

      repeat (3) @(negedge clk);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.rd_valid", rd_valid, 1'b0);
      chk("rst.rd_data", rd_data, 8'h00);
      chk("rst.enable_div", enable_div, 1'b0);
      chk("rst.cs_n", cs_n, 1'b1);
      chk("rst.mosi", mosi, 1'b0);
      chk("rst.sclk", sclk, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 5; t++) begin
         launch(tbl[t].r, tbl[t].a, tbl[t].wd, tbl[t].n, tbl[t].resp);
         wait_done($sformatf("tbl%0d", t));
         verify($sformatf("tbl%0d", t), tbl[t].r, tbl[t].a, tbl[t].wd,
                tbl[t].n, tbl[t].resp, tbl[t].exp_cmd,
                tbl[t].exp_rises, tbl[t].exp_nval);
      end

      // start while busy with a different command is ignored
      launch(1'b1, 7'h50, 8'h00, 3'd1, 48'h58_00_00_00_00_00);
      repeat (30) @(negedge clk);
      chk("poke.busy", busy, 1'b1);
      start   = 1'b1;
      rw      = 1'b0;
      addr    = 7'h11;
      wr_data = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      wait_done("poke");
      verify("poke", 1'b1, 7'h50, 8'h00, 3'd1, 48'h58_00_00_00_00_00,
             8'hD0, 16, 1);

      // reset during the third data byte of a burst read
      launch(1'b1, 7'h77, 8'h00, 3'd6, 48'h11_22_33_44_55_66);
      k = 0;
      while (srise < 27 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("mid.reached_byte3", srise >= 27, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid.cs_n", cs_n, 1'b1);
      chk("mid.enable_div", enable_div, 1'b0);
      chk("mid.busy", busy, 1'b0);
      chk("mid.done", done, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid.no_done", done_cnt, 0);
      chk("mid.bytes_before", got.size(), 2);
      chk("mid.still_idle", busy, 1'b0);
      launch(1'b0, 7'h74, 8'h27, 3'd3, 48'h0);
      wait_done("after_rst");
      verify("after_rst", 1'b0, 7'h74, 8'h27, 3'd3, 48'h0,
             8'h74, 16, 0);

      // random transactions checked against the transaction model
      for (int t = 0; t < 8; t++) begin
         rnd = {$urandom, $urandom};
         rr  = 1'($urandom_range(0, 1));
         ra  = 7'($urandom_range(0, 127));
         rwd = 8'($urandom_range(0, 255));
         rn  = 3'($urandom_range(0, 7));
         launch(rr, ra, rwd, rn, rnd[47:0]);
         wait_done($sformatf("rnd%0d", t));
         verify($sformatf("rnd%0d", t), rr, ra, rwd, rn, rnd[47:0],
                {rr, ra}, 8 * (1 + model_n(rr, rn)),
                rr ? model_n(rr, rn) : 0);
      end

      chk("sclk_low_when_cs_high", sclk_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
